// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared state encoding and message width for pipe stages.
// Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

    localparam int MSG_W = 8;

    typedef logic [0:0] pipeState_t;

    localparam pipeState_t IDLE = 1'b0;
    localparam pipeState_t WAIT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pipe_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker; first set request at or after ptr.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [IDW-1:0] o_grant,
    output logic           o_anyValid
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;

    // Doubling the vector turns the wrap-around search into a plain shift.
    assign w_dbl = {i_req, i_req};
    assign w_rot = N'(w_dbl >> i_ptr);

    // Descending loop so the lowest rotated position wins.
    always_comb begin
        int sum;
        o_grant = '0;
        sum     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                sum = int'(i_ptr) + k;
                if (sum >= N) begin
                    sum = sum - N;
                end
                o_grant = IDW'(sum);
            end
        end
    end

    assign o_anyValid = |i_req;

endmodule
`default_nettype wire

// File: rtl/pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pipe_arbiter
// Purpose  : Round-robin arbiter sharing one pipe input among N requesters.
// Revision : 1.0  initial release
// ============================================================================
module pipe_arbiter
    import pipe_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = MSG_W,
    parameter int IDW = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   rReady,
    input  logic [N*W-1:0] rMsg,
    output logic [N-1:0]   rGet,
    input  logic [N-1:0]   iMask,
    output logic           oReady,
    output logic [W-1:0]   oMsg,
    output logic [IDW-1:0] oId,
    input  logic           oGet,
    output logic [7:0]     oCount
);

    pipeState_t     r_state;
    pipeState_t     w_nextState;
    logic [IDW-1:0] r_ptr;
    logic [N-1:0]   r_get;
    logic           r_ready;
    logic [W-1:0]   r_msg;
    logic [IDW-1:0] r_id;
    logic [7:0]     r_count;

    logic [N-1:0]   w_elig;
    logic [IDW-1:0] w_grant;
    logic           w_any;
    logic           w_capture;
    logic           w_complete;
    logic [W-1:0]   w_grantMsg;
    logic [N-1:0]   w_grantOneHot;
    logic [IDW-1:0] w_ptrNext;

    assign w_elig = rReady & iMask;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .i_req      (w_elig),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_anyValid (w_any)
    );

    // Message mux and grant one-hot, one slice per requester.
    always_comb begin
        w_grantMsg    = '0;
        w_grantOneHot = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == IDW'(i)) begin
                w_grantMsg       = rMsg[i*W +: W];
                w_grantOneHot[i] = 1'b1;
            end
        end
    end

    assign w_ptrNext = (r_id == IDW'(N - 1)) ? '0 : r_id + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_any) w_nextState = WAIT;
            WAIT:    if (oGet)  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_capture  = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            IDLE:    w_capture  = w_any;
            WAIT:    w_complete = oGet;
            default: ;
        endcase
    end

    // ptr moves only on completion, so a held transfer never skips anyone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr   <= '0;
            r_get   <= '0;
            r_ready <= 1'b0;
            r_msg   <= '0;
            r_id    <= '0;
            r_count <= '0;
        end else begin
            r_get <= w_capture ? w_grantOneHot : '0;
            if (w_capture) begin
                r_ready <= 1'b1;
                r_msg   <= w_grantMsg;
                r_id    <= w_grant;
            end
            if (w_complete) begin
                r_ready <= 1'b0;
                r_ptr   <= w_ptrNext;
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign rGet   = r_get;
    assign oReady = r_ready;
    assign oMsg   = r_msg;
    assign oId    = r_id;
    assign oCount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_arbiter
// Purpose  : Directed self-checking bench for pipe_arbiter (N=4, W=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   rReady = '0;
    logic [N*W-1:0] rMsg = {8'd40, 8'd30, 8'd20, 8'd10};
    logic [N-1:0]   rGet;
    logic [N-1:0]   iMask = '1;
    logic           oReady;
    logic [W-1:0]   oMsg;
    logic [IDW-1:0] oId;
    logic           oGet = 1'b0;
    logic [7:0]     oCount;

    int total = 0;
    int bad   = 0;

    // {rGet, oReady, oId, oMsg}
    logic [14:0] obs;
    assign obs = {rGet, oReady, oId, oMsg};

    always #5 clock = ~clock;

    pipe_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
        .clock  (clock),
        .reset  (reset),
        .rReady (rReady),
        .rMsg   (rMsg),
        .rGet   (rGet),
        .iMask  (iMask),
        .oReady (oReady),
        .oMsg   (oMsg),
        .oId    (oId),
        .oGet   (oGet),
        .oCount (oCount)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        rReady = '0;
        iMask  = '1;
        oGet   = 1'b0;
        tick();
        tick();
        reset  = 1'b1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        rReady = 4'b1111;
        iMask  = 4'b1111;
        oGet   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if ({obs, oCount} !== 23'd0) begin
                bad++;
                $display("FAIL reset_hold[%0d] got obs=%h cnt=%0d want all zero", c, obs, oCount);
            end
        end
        reset = 1'b1;
        tick();
        total++;
        if (obs !== {4'b0001, 1'b1, 2'd0, 8'd10}) begin
            bad++;
            $display("FAIL reset_first_grant got=%h want=%h", obs, {4'b0001, 1'b1, 2'd0, 8'd10});
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        rReady = 4'b1111;
        oGet   = 1'b1;
        for (int t = 0; t < 5; t++) begin
            int id;
            id = t % 4;
            tick();
            total++;
            if (obs !== {4'(1 << id), 1'b1, 2'(id), 8'((id + 1) * 10)}) begin
                bad++;
                $display("FAIL rr_grant[%0d] got=%h want=%h", t, obs,
                         {4'(1 << id), 1'b1, 2'(id), 8'((id + 1) * 10)});
            end
            tick();
            total++;
            if ({rGet, oReady, oCount} !== {4'b0, 1'b0, 8'(t + 1)}) begin
                bad++;
                $display("FAIL rr_done[%0d] got rGet=%b rdy=%b cnt=%0d want 0/0/%0d",
                         t, rGet, oReady, oCount, t + 1);
            end
        end
        oGet   = 1'b0;
        rReady = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        rReady = 4'b0100;
        tick();
        total++;
        if (obs !== {4'b0100, 1'b1, 2'd2, 8'd30}) begin
            bad++;
            $display("FAIL bp_capture got=%h want=%h", obs, {4'b0100, 1'b1, 2'd2, 8'd30});
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if ({obs, oCount} !== {4'b0000, 1'b1, 2'd2, 8'd30, 8'd0}) begin
                bad++;
                $display("FAIL bp_hold[%0d] got obs=%h cnt=%0d want obs=%h cnt=0",
                         c, obs, oCount, {4'b0000, 1'b1, 2'd2, 8'd30});
            end
        end
        oGet   = 1'b1;
        rReady = '0;
        tick();
        total++;
        if ({rGet, oReady, oCount} !== {4'b0, 1'b0, 8'd1}) begin
            bad++;
            $display("FAIL bp_done got rGet=%b rdy=%b cnt=%0d want 0/0/1", rGet, oReady, oCount);
        end
        oGet   = 1'b0;
        rReady = 4'b1111;
        tick();
        total++;
        if (obs !== {4'b1000, 1'b1, 2'd3, 8'd40}) begin
            bad++;
            $display("FAIL bp_next_ptr got=%h want=%h", obs, {4'b1000, 1'b1, 2'd3, 8'd40});
        end
        rReady = '0;
    endtask

    task automatic test_masking();
        do_reset();
        rReady = 4'b1010;
        iMask  = 4'b0010;
        oGet   = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tick();
            total++;
            if (obs !== {4'b0010, 1'b1, 2'd1, 8'd20}) begin
                bad++;
                $display("FAIL mask_grant[%0d] got=%h want=%h", r, obs, {4'b0010, 1'b1, 2'd1, 8'd20});
            end
            tick();
            total++;
            if ({rGet, oReady} !== 5'b0) begin
                bad++;
                $display("FAIL mask_done[%0d] got rGet=%b rdy=%b want 0/0", r, rGet, oReady);
            end
        end
        iMask = 4'b1010;
        tick();
        total++;
        if (obs !== {4'b1000, 1'b1, 2'd3, 8'd40}) begin
            bad++;
            $display("FAIL mask_unmask got=%h want=%h", obs, {4'b1000, 1'b1, 2'd3, 8'd40});
        end
        tick();
        oGet   = 1'b0;
        rReady = '0;
        iMask  = '1;
    endtask

    task automatic test_wrap_skip();
        do_reset();
        rReady = 4'b0100;
        oGet   = 1'b1;
        tick();
        rReady = 4'b0001;
        tick();
        tick();
        total++;
        if (obs !== {4'b0001, 1'b1, 2'd0, 8'd10}) begin
            bad++;
            $display("FAIL wrap_ptr3 got=%h want=%h", obs, {4'b0001, 1'b1, 2'd0, 8'd10});
        end

        do_reset();
        rReady = 4'b1000;
        oGet   = 1'b1;
        tick();
        // Changing rReady while WAIT must not disturb the transfer in flight.
        rReady = 4'b1001;
        tick();
        total++;
        if ({oId, oMsg, oReady} !== {2'd3, 8'd40, 1'b0}) begin
            bad++;
            $display("FAIL skip_first got id=%0d msg=%0d rdy=%b want 3/40/0", oId, oMsg, oReady);
        end
        tick();
        total++;
        if (obs !== {4'b0001, 1'b1, 2'd0, 8'd10}) begin
            bad++;
            $display("FAIL skip_zero got=%h want=%h", obs, {4'b0001, 1'b1, 2'd0, 8'd10});
        end
        tick();
        tick();
        total++;
        if (obs !== {4'b1000, 1'b1, 2'd3, 8'd40}) begin
            bad++;
            $display("FAIL skip_three got=%h want=%h", obs, {4'b1000, 1'b1, 2'd3, 8'd40});
        end
        oGet   = 1'b0;
        rReady = '0;
    endtask

    task automatic test_idle_oget();
        do_reset();
        oGet = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({rGet, oReady, oCount} !== 13'd0) begin
                bad++;
                $display("FAIL idle_oget[%0d] got rGet=%b rdy=%b cnt=%0d want 0/0/0",
                         c, rGet, oReady, oCount);
            end
        end
        oGet = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        rReady = 4'b0001;
        oGet   = 1'b1;
        tick();
        tick();
        oGet = 1'b0;
        tick();
        total++;
        if ({oReady, oId, oCount} !== {1'b1, 2'd0, 8'd1}) begin
            bad++;
            $display("FAIL areset_pre got rdy=%b id=%0d cnt=%0d want 1/0/1", oReady, oId, oCount);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({obs, oCount} !== 23'd0) begin
            bad++;
            $display("FAIL areset_clear got obs=%h cnt=%0d want all zero", obs, oCount);
        end
        reset  = 1'b1;
        rReady = 4'b1111;
        tick();
        total++;
        if ({obs, oCount} !== {4'b0001, 1'b1, 2'd0, 8'd10, 8'd0}) begin
            bad++;
            $display("FAIL areset_restart got obs=%h cnt=%0d want obs=%h cnt=0",
                     obs, oCount, {4'b0001, 1'b1, 2'd0, 8'd10});
        end
        rReady = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_masking();
        test_wrap_skip();
        test_idle_oget();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
